lcd_timing_gen: RTL and testbench

Parametrised RGB565 parallel-LCD timing and pixel-source block driving 480x272-class DE/HSYNC/VSYNC panels from PixelClk. Generates programmable porch/sync timing with selectable polarities and a pixel request/coordinate interface toward a frame-buffer reader. An optional built-in pattern generator provides solid, colour-bar and grid test images. Sits between the pixel-clock PLL and the LCD pins at top level.

---
 rtl/lcd_timing_pkg.sv | 44 ++++
 rtl/lcd_timing_gen_if.sv | 14 +
 rtl/lcd_pattern_gen.sv | 43 ++++
 rtl/lcd_timing_gen.sv | 184 ++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared types and constants for the RGB565 LCD timing generator and its test-pattern source.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_GRID  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam rgb565_t BAR_WHITE   = 16'hFFFF;
  localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
  localparam rgb565_t BAR_CYAN    = 16'h07FF;
  localparam rgb565_t BAR_GREEN   = 16'h07E0;
  localparam rgb565_t BAR_MAGENTA = 16'hF81F;
  localparam rgb565_t BAR_RED     = 16'hF800;
  localparam rgb565_t BAR_BLUE    = 16'h001F;
  localparam rgb565_t BAR_BLACK   = 16'h0000;

  function automatic rgb565_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Pixel-source port between the LCD timing generator (master) and a frame-buffer reader (slave).
interface lcd_timing_gen_if #(
  parameter int X_W = 9,
  parameter int Y_W = 9
);
  logic           pix_req;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic           frame_start;
  logic [15:0]    ext_rgb;

  modport master (output pix_req, pix_x, pix_y, frame_start, input ext_rgb);
  modport slave  (input pix_req, pix_x, pix_y, frame_start, output ext_rgb);
endinterface

// File: rtl/lcd_pattern_gen.sv
// Built-in test image source: solid colour, eight vertical colour bars, or a 16-pixel grid.
// The colour is registered once so it lines up with the LCD pin stage.
module lcd_pattern_gen
  import lcd_timing_pkg::*;
#(
  parameter int          H_ACTIVE    = 480,
  parameter int          X_W         = 9,
  parameter int          Y_W         = 9,
  parameter logic [15:0] SOLID_COLOR = 16'h001F
) (
  input  logic           PixelClk,
  input  mode_e          mode_q,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  output rgb565_t        pat_p2
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  rgb565_t    pat_p1;

  always_comb begin
    // The last bar absorbs any remainder of H_ACTIVE/8.
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (int'(pix_x) >= i * BAR_W) bar_idx = 3'(i);
    end
    case (mode_q)
      MODE_SOLID: pat_p1 = rgb565_t'(SOLID_COLOR);
      MODE_BARS:  pat_p1 = bar_color(bar_idx);
      MODE_GRID:  pat_p1 = (((pix_x & X_W'(15)) == '0) || ((pix_y & Y_W'(15)) == '0))
                           ? rgb565_t'(16'hFFFF) : rgb565_t'(16'h0000);
      default:    pat_p1 = '0;
    endcase
  end

  // stage 1 -> stage 2
  always_ff @(posedge PixelClk) begin
    pat_p2 <= pat_p1;
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB565 parallel-LCD timing generator: porch/sync counters, pixel request port, registered LCD pins.
// Define LCD_PATTERN_EN to build the solid / colour-bar / grid test-pattern source.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int          H_ACTIVE    = 480,
  parameter int          H_FP        = 8,
  parameter int          H_SYNC      = 4,
  parameter int          H_BP        = 43,
  parameter int          V_ACTIVE    = 272,
  parameter int          V_FP        = 8,
  parameter int          V_SYNC      = 4,
  parameter int          V_BP        = 12,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter logic [15:0] SOLID_COLOR = 16'h001F
) (
  input  logic             PixelClk,
  input  logic             nRST,
  input  logic             en,
  input  logic [1:0]       mode,
  lcd_timing_gen_if.master pix,
  output logic             LCD_DE,
  output logic             LCD_HSYNC,
  output logic             LCD_VSYNC,
  output logic [4:0]       LCD_R,
  output logic [5:0]       LCD_G,
  output logic [4:0]       LCD_B
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int X_W      = $clog2(H_ACTIVE);
  localparam int Y_W      = $clog2(V_ACTIVE);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;

  state_e         state_q, state_d;
  logic           frame_load;
  logic [H_W-1:0] h_p0;
  logic [V_W-1:0] v_p0;
  logic           run_p0, line_end_p0, frame_end_p0;
  logic           active_p0, hs_p0, vs_p0, fs_p0;

  logic           pix_req_p1, frame_start_p1, hs_p1, vs_p1;
  logic [X_W-1:0] pix_x_p1;
  logic [Y_W-1:0] pix_y_p1;

  rgb565_t        ext_p2, rgb_out;

  assign run_p0       = (state_q == ST_RUN);
  assign line_end_p0  = (h_p0 == H_W'(H_TOTAL - 1));
  assign frame_end_p0 = line_end_p0 && (v_p0 == V_W'(V_TOTAL - 1));

  // en is only honoured at a frame boundary: from IDLE, or on the last pixel of the last line.
  always_comb begin
    state_d    = state_q;
    frame_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d    = ST_RUN;
          frame_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_end_p0) begin
          if (en) frame_load = 1'b1;
          else    state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      h_p0    <= '0;
      v_p0    <= '0;
    end else begin
      state_q <= state_d;
      h_p0    <= (!run_p0 || line_end_p0) ? '0 : h_p0 + 1'b1;
      if (!run_p0 || frame_end_p0) v_p0 <= '0;
      else if (line_end_p0)        v_p0 <= v_p0 + 1'b1;
    end
  end

  assign active_p0 = run_p0 && (h_p0 < H_W'(H_ACTIVE)) && (v_p0 < V_W'(V_ACTIVE));
  assign hs_p0     = run_p0 && (h_p0 >= H_W'(HS_START)) && (h_p0 < H_W'(HS_START + H_SYNC));
  assign vs_p0     = run_p0 && (v_p0 >= V_W'(VS_START)) && (v_p0 < V_W'(VS_START + V_SYNC));
  assign fs_p0     = run_p0 && (h_p0 == '0) && (v_p0 == '0);

  // stage 0 -> stage 1: pixel request and coordinates
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      pix_req_p1     <= 1'b0;
      pix_x_p1       <= '0;
      pix_y_p1       <= '0;
      frame_start_p1 <= 1'b0;
      hs_p1          <= 1'b0;
      vs_p1          <= 1'b0;
    end else begin
      pix_req_p1     <= active_p0;
      pix_x_p1       <= active_p0 ? h_p0[X_W-1:0] : '0;
      pix_y_p1       <= active_p0 ? v_p0[Y_W-1:0] : '0;
      frame_start_p1 <= fs_p0;
      hs_p1          <= hs_p0;
      vs_p1          <= vs_p0;
    end
  end

  assign pix.pix_req     = pix_req_p1;
  assign pix.pix_x       = pix_x_p1;
  assign pix.pix_y       = pix_y_p1;
  assign pix.frame_start = frame_start_p1;

  // stage 1 -> stage 2: LCD pins
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      LCD_DE    <= 1'b0;
      LCD_HSYNC <= ~HS_POL;
      LCD_VSYNC <= ~VS_POL;
    end else begin
      LCD_DE    <= pix_req_p1;
      LCD_HSYNC <= hs_p1 ? HS_POL : ~HS_POL;
      LCD_VSYNC <= vs_p1 ? VS_POL : ~VS_POL;
    end
  end

  always_ff @(posedge PixelClk) begin
    ext_p2 <= rgb565_t'(pix.ext_rgb);
  end

`ifdef LCD_PATTERN_EN
  mode_e   mode_q;
  logic    use_ext_p2;
  rgb565_t pat_p2;

  // mode is captured together with the counter wrap so a whole frame uses one source.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      mode_q     <= MODE_EXT;
      use_ext_p2 <= 1'b1;
    end else begin
      if (frame_load) mode_q <= mode_e'(mode);
      use_ext_p2 <= (mode_q == MODE_EXT);
    end
  end

  lcd_pattern_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .X_W         (X_W),
    .Y_W         (Y_W),
    .SOLID_COLOR (SOLID_COLOR)
  ) u_pattern (
    .PixelClk (PixelClk),
    .mode_q   (mode_q),
    .pix_x    (pix_x_p1),
    .pix_y    (pix_y_p1),
    .pat_p2   (pat_p2)
  );

  always_comb begin
    rgb_out = '0;
    if (LCD_DE) rgb_out = use_ext_p2 ? ext_p2 : pat_p2;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode, SOLID_COLOR, frame_load};

  always_comb begin
    rgb_out = '0;
    if (LCD_DE) rgb_out = ext_p2;
  end
`endif

  assign LCD_R = rgb_out.r;
  assign LCD_G = rgb_out.g;
  assign LCD_B = rgb_out.b;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: full horizontal timing with a shortened vertical frame.
module tb_lcd_timing_gen;

  localparam int HA = 480, HFP = 8, HSW = 4, HBP = 43, H_TOT = 535;
  localparam int VA = 9, VFP = 2, VSW = 2, VBP = 2, V_TOT = 15;
  localparam int F_TOT = H_TOT * V_TOT;

  logic        PixelClk = 1'b0;
  logic        nRST;
  logic        en;
  logic [1:0]  mode;
  logic        LCD_DE, LCD_HSYNC, LCD_VSYNC;
  logic [4:0]  LCD_R;
  logic [5:0]  LCD_G;
  logic [4:0]  LCD_B;
  logic [15:0] rgb;

  int n_cmp  = 0;
  int n_fail = 0;
  int ft     = 0;

  lcd_timing_gen_if #(.X_W(9), .Y_W(4)) pif ();

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .SOLID_COLOR(16'h001F)
  ) dut (
    .PixelClk (PixelClk),
    .nRST     (nRST),
    .en       (en),
    .mode     (mode),
    .pix      (pif),
    .LCD_DE   (LCD_DE),
    .LCD_HSYNC(LCD_HSYNC),
    .LCD_VSYNC(LCD_VSYNC),
    .LCD_R    (LCD_R),
    .LCD_G    (LCD_G),
    .LCD_B    (LCD_B)
  );

  always #5 PixelClk = ~PixelClk;

  assign rgb = {LCD_R, LCD_G, LCD_B};

  // Frame-buffer stand-in: answers each request with {y, 000, x} during the request cycle.
  always @(negedge PixelClk)
    pif.ext_rgb = pif.pix_req ? {pif.pix_y, 3'b000, pif.pix_x} : 16'hBAD0;

  function automatic logic [15:0] ext_val(input int h, input int v);
    return {v[3:0], 3'b000, h[8:0]};
  endfunction

  task automatic wait_fs(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge PixelClk);
      if (pif.frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    ft = 0;
  endtask

  task automatic advance_to(input int target);
    while (ft < target) begin
      @(negedge PixelClk);
      ft++;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; en = 1'b1; mode = 2'd0;
    repeat (3) @(negedge PixelClk);
    n_cmp++;
    if ({LCD_DE, LCD_HSYNC, LCD_VSYNC} !== 3'b011) begin
      n_fail++; $display("FAIL reset_lcd_ctrl: got %b want 011", {LCD_DE, LCD_HSYNC, LCD_VSYNC});
    end
    n_cmp++;
    if (rgb !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rgb: got %h want 0000", rgb);
    end
    n_cmp++;
    if ({pif.pix_req, pif.frame_start, pif.pix_x, pif.pix_y} !== 15'd0) begin
      n_fail++; $display("FAIL reset_pix: req=%b fs=%b x=%0d y=%0d want all 0",
                         pif.pix_req, pif.frame_start, pif.pix_x, pif.pix_y);
    end
    nRST = 1'b1;
    @(negedge PixelClk);
    n_cmp++;
    if (pif.pix_req !== 1'b0) begin
      n_fail++; $display("FAIL release_cycle1_req: got %b want 0", pif.pix_req);
    end
    @(negedge PixelClk);
    n_cmp++;
    if ({pif.pix_req, pif.frame_start, pif.pix_x, pif.pix_y} !== {2'b11, 13'd0}) begin
      n_fail++; $display("FAIL release_first_req: req=%b fs=%b x=%0d y=%0d want 1 1 0 0",
                         pif.pix_req, pif.frame_start, pif.pix_x, pif.pix_y);
    end
    ft = 0;
  endtask

  task automatic test_timing();
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0;
    int req_err = 0, de_err = 0, sync_err = 0, data_err = 0;
    int first_fall = -1, second_fall = -1, second_fs = -1;
    logic prev_hs = 1'b1;
    for (int t = 0; t < 2 * F_TOT; t++) begin
      int h1, v1, s2, h2, v2;
      bit req_e, de_e, hs_e, vs_e;
      h1 = (t % F_TOT) % H_TOT;
      v1 = (t % F_TOT) / H_TOT;
      s2 = (t + F_TOT - 1) % F_TOT;
      h2 = s2 % H_TOT;
      v2 = s2 / H_TOT;
      req_e = (h1 < HA) && (v1 < VA);
      de_e  = (h2 < HA) && (v2 < VA);
      hs_e  = (h2 >= HA + HFP) && (h2 < HA + HFP + HSW);
      vs_e  = (v2 >= VA + VFP) && (v2 < VA + VFP + VSW);
      if (pif.pix_req !== req_e || pif.frame_start !== ((t % F_TOT) == 0) ||
          (req_e && (pif.pix_x !== 9'(h1) || pif.pix_y !== 4'(v1)))) req_err++;
      if (LCD_DE !== de_e) de_err++;
      if (LCD_HSYNC !== !hs_e || LCD_VSYNC !== !vs_e) sync_err++;
      if (rgb !== (de_e ? ext_val(h2, v2) : 16'h0000)) data_err++;
      if (LCD_DE === 1'b1) de_cnt++;
      if (LCD_HSYNC === 1'b0) hs_cnt++;
      if (LCD_VSYNC === 1'b0) vs_cnt++;
      if (prev_hs === 1'b1 && LCD_HSYNC === 1'b0) begin
        if (first_fall < 0) first_fall = t;
        else if (second_fall < 0) second_fall = t;
      end
      prev_hs = LCD_HSYNC;
      if (t > 0 && second_fs < 0 && pif.frame_start === 1'b1) second_fs = t;
      @(negedge PixelClk);
    end
    ft = 0;
    n_cmp++; if (de_cnt !== 2 * HA * VA) begin n_fail++; $display("FAIL de_count: got %0d want %0d", de_cnt, 2 * HA * VA); end
    n_cmp++; if (hs_cnt !== 2 * V_TOT * HSW) begin n_fail++; $display("FAIL hsync_low_count: got %0d want %0d", hs_cnt, 2 * V_TOT * HSW); end
    n_cmp++; if (vs_cnt !== 2 * VSW * H_TOT) begin n_fail++; $display("FAIL vsync_low_count: got %0d want %0d", vs_cnt, 2 * VSW * H_TOT); end
    n_cmp++; if (first_fall !== 489) begin n_fail++; $display("FAIL hsync_first_fall: got %0d want 489", first_fall); end
    n_cmp++; if (second_fall !== 489 + H_TOT) begin n_fail++; $display("FAIL line_period: got %0d want %0d", second_fall, 489 + H_TOT); end
    n_cmp++; if (second_fs !== F_TOT) begin n_fail++; $display("FAIL frame_period: got %0d want %0d", second_fs, F_TOT); end
    n_cmp++; if (req_err !== 0) begin n_fail++; $display("FAIL pix_req_coords: got %0d bad cycles want 0", req_err); end
    n_cmp++; if (de_err !== 0) begin n_fail++; $display("FAIL de_alignment: got %0d bad cycles want 0", de_err); end
    n_cmp++; if (sync_err !== 0) begin n_fail++; $display("FAIL sync_alignment: got %0d bad cycles want 0", sync_err); end
    n_cmp++; if (data_err !== 0) begin n_fail++; $display("FAIL ext_data: got %0d bad cycles want 0", data_err); end
  endtask

  task automatic test_mode_change();
    n_cmp++;
    if (pif.frame_start !== 1'b1) begin
      n_fail++; $display("FAIL frame3_start: got %b want 1", pif.frame_start);
    end
    mode = 2'd2;
    advance_to(61);
    n_cmp++;
    if (rgb !== ext_val(60, 0)) begin
      n_fail++; $display("FAIL midframe_mode_ignored: got %h want %h", rgb, ext_val(60, 0));
    end
  endtask

  task automatic test_bars();
    bit ok;
    logic [15:0] e0, e60, e479, e60l1;
`ifdef LCD_PATTERN_EN
    e0 = 16'hFFFF; e60 = 16'hFFE0; e479 = 16'h0000; e60l1 = 16'hFFE0;
`else
    e0 = ext_val(0, 0); e60 = ext_val(60, 0); e479 = ext_val(479, 0); e60l1 = ext_val(60, 1);
`endif
    wait_fs(F_TOT + 10, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL frame4_start: got timeout want frame_start"); end
    advance_to(1);
    n_cmp++; if (rgb !== e0) begin n_fail++; $display("FAIL bars_px0: got %h want %h", rgb, e0); end
    advance_to(61);
    n_cmp++; if (rgb !== e60) begin n_fail++; $display("FAIL bars_px60: got %h want %h", rgb, e60); end
    advance_to(480);
    n_cmp++; if (rgb !== e479) begin n_fail++; $display("FAIL bars_px479: got %h want %h", rgb, e479); end
    mode = 2'd0;
    advance_to(H_TOT + 61);
    n_cmp++; if (rgb !== e60l1) begin n_fail++; $display("FAIL bars_hold_line1: got %h want %h", rgb, e60l1); end
  endtask

  task automatic test_ext_latency();
    bit ok;
    wait_fs(F_TOT + 10, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL frame5_start: got timeout want frame_start"); end
    n_cmp++;
    if ({pif.pix_req, LCD_DE} !== 2'b10) begin
      n_fail++; $display("FAIL ext_req_before_de: got req/de %b want 10", {pif.pix_req, LCD_DE});
    end
    advance_to(1);
    n_cmp++;
    if ({LCD_DE, pif.pix_x} !== {1'b1, 9'd1}) begin
      n_fail++; $display("FAIL ext_de_next: got de=%b x=%0d want de=1 x=1", LCD_DE, pif.pix_x);
    end
    advance_to(6);
    n_cmp++; if (rgb !== 16'd5) begin n_fail++; $display("FAIL ext_px5: got %h want 0005", rgb); end
    advance_to(61);
    n_cmp++; if (rgb !== 16'd60) begin n_fail++; $display("FAIL ext_mode_restored: got %h want 003c", rgb); end
  endtask

  task automatic test_en_drop();
    int req_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
    advance_to(5 * H_TOT);
    en = 1'b0;
    while (ft < F_TOT + 600) begin
      if (pif.pix_req === 1'b1) req_cnt++;
      if (LCD_HSYNC === 1'b0) hs_cnt++;
      if (LCD_VSYNC === 1'b0) vs_cnt++;
      if (pif.frame_start === 1'b1) fs_cnt++;
      @(negedge PixelClk);
      ft++;
    end
    n_cmp++; if (req_cnt !== 4 * HA) begin n_fail++; $display("FAIL drop_req_count: got %0d want %0d", req_cnt, 4 * HA); end
    n_cmp++; if (hs_cnt !== 10 * HSW) begin n_fail++; $display("FAIL drop_hsync_count: got %0d want %0d", hs_cnt, 10 * HSW); end
    n_cmp++; if (vs_cnt !== VSW * H_TOT) begin n_fail++; $display("FAIL drop_vsync_count: got %0d want %0d", vs_cnt, VSW * H_TOT); end
    n_cmp++; if (fs_cnt !== 0) begin n_fail++; $display("FAIL drop_no_restart: got %0d frame starts want 0", fs_cnt); end
    n_cmp++;
    if ({pif.pix_req, LCD_DE, LCD_HSYNC, LCD_VSYNC} !== 4'b0011) begin
      n_fail++; $display("FAIL drop_idle: got %b want 0011", {pif.pix_req, LCD_DE, LCD_HSYNC, LCD_VSYNC});
    end
  endtask

  task automatic test_nrst_mid();
    bit ok;
    en = 1'b1;
    wait_fs(10, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL restart_from_idle: got timeout want frame_start"); end
    advance_to(3 * H_TOT + 100);
    n_cmp++;
    if ({LCD_DE, rgb} !== {1'b1, ext_val(99, 3)}) begin
      n_fail++; $display("FAIL pre_reset_px: got de=%b rgb=%h want de=1 rgb=%h", LCD_DE, rgb, ext_val(99, 3));
    end
    #2 nRST = 1'b0;
    #1;
    n_cmp++;
    if ({LCD_DE, LCD_HSYNC, LCD_VSYNC, rgb} !== {3'b011, 16'h0000}) begin
      n_fail++; $display("FAIL async_reset_lcd: got de/hs/vs=%b rgb=%h want 011 0000",
                         {LCD_DE, LCD_HSYNC, LCD_VSYNC}, rgb);
    end
    n_cmp++;
    if ({pif.pix_req, pif.frame_start, pif.pix_x, pif.pix_y} !== 15'd0) begin
      n_fail++; $display("FAIL async_reset_pix: req=%b x=%0d y=%0d want 0 0 0", pif.pix_req, pif.pix_x, pif.pix_y);
    end
    repeat (3) @(negedge PixelClk);
    nRST = 1'b1;
    @(negedge PixelClk);
    @(negedge PixelClk);
    n_cmp++;
    if ({pif.frame_start, pif.pix_x, pif.pix_y} !== {1'b1, 13'd0}) begin
      n_fail++; $display("FAIL recover_origin: fs=%b x=%0d y=%0d want 1 0 0", pif.frame_start, pif.pix_x, pif.pix_y);
    end
    @(negedge PixelClk);
    @(negedge PixelClk);
    n_cmp++;
    if ({LCD_DE, rgb} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL recover_px1: got de=%b rgb=%h want de=1 rgb=0001", LCD_DE, rgb);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_mode_change();
    test_bars();
    test_ext_latency();
    test_en_drop();
    test_nrst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
